// File: rtl/sdram_arbiter.sv
// Three-master Wishbone arbiter in front of the SDRAM controller slave port.
// Fixed priority video > sound > CPU, CPU starvation guard, idle gap between owners.
module sdram_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int GAP_CYCLES   = 2
) (
    input  logic        wb_clk,
    input  logic        wb_rst,
    input  logic [2:0]  m_cyc,
    input  logic [2:0]  m_stb,
    input  logic [2:0]  m_we,
    input  logic [65:0] m_adr,
    input  logic [11:0] m_sel,
    input  logic [8:0]  m_cti,
    input  logic [95:0] m_dat_i,
    output logic [2:0]  m_ack,
    output logic [31:0] m_dat_o,
    output logic        s_cyc,
    output logic        s_stb,
    output logic        s_we,
    output logic [21:0] s_adr,
    output logic [3:0]  s_sel,
    output logic [2:0]  s_cti,
    output logic [31:0] s_dat_o,
    input  logic        s_ack,
    input  logic [31:0] s_dat_i,
    output logic [2:0]  grant
);

    typedef enum logic [1:0] {
        IDLE,
        BUS,
        GAP
    } state_t;

    localparam logic [3:0] LIMIT    = 4'(STARVE_LIMIT);
    localparam logic [3:0] GAP_INIT = 4'(GAP_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] grant_q, grant_d;
    logic [3:0] starve_q, starve_d;
    logic [3:0] gap_q, gap_d;

    logic [2:0]  req;
    logic [2:0]  win;
    logic        own_cyc;
    logic        own_stb;
    logic        own_we;
    logic [21:0] own_adr;
    logic [3:0]  own_sel;
    logic [2:0]  own_cti;
    logic [31:0] own_dat;

    assign req = m_cyc & m_stb;

    // CPU is forced through once it has lost STARVE_LIMIT arbitrations in a row
    always_comb begin
        win = 3'b000;
        if (req[2] && (starve_q >= LIMIT)) begin
            win = 3'b100;
        end else if (req[0]) begin
            win = 3'b001;
        end else if (req[1]) begin
            win = 3'b010;
        end else if (req[2]) begin
            win = 3'b100;
        end
    end

    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_sel = '0;
        own_cti = '0;
        own_dat = '0;
        case (grant_q)
            3'b001: begin
                own_cyc = m_cyc[0];
                own_stb = m_stb[0];
                own_we  = m_we[0];
                own_adr = m_adr[21:0];
                own_sel = m_sel[3:0];
                own_cti = m_cti[2:0];
                own_dat = m_dat_i[31:0];
            end
            3'b010: begin
                own_cyc = m_cyc[1];
                own_stb = m_stb[1];
                own_we  = m_we[1];
                own_adr = m_adr[43:22];
                own_sel = m_sel[7:4];
                own_cti = m_cti[5:3];
                own_dat = m_dat_i[63:32];
            end
            3'b100: begin
                own_cyc = m_cyc[2];
                own_stb = m_stb[2];
                own_we  = m_we[2];
                own_adr = m_adr[65:44];
                own_sel = m_sel[11:8];
                own_cti = m_cti[8:6];
                own_dat = m_dat_i[95:64];
            end
            default: begin
                own_cyc = 1'b0;
            end
        endcase
    end

    // grant_q is only non-zero in BUS, so the mux alone zeroes the slave side
    assign s_cyc   = own_cyc;
    assign s_stb   = own_stb;
    assign s_we    = own_we;
    assign s_adr   = own_adr;
    assign s_sel   = own_sel;
    assign s_cti   = own_cti;
    assign s_dat_o = own_dat;
    assign m_ack   = grant_q & {3{s_ack & own_cyc}};
    assign m_dat_o = (state_q == BUS) ? s_dat_i : 32'h0;
    assign grant   = grant_q;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        starve_d = starve_q;
        gap_d    = gap_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUS;
                    grant_d = win;
                    if (req[2]) begin
                        if (win[2]) begin
                            starve_d = 4'd0;
                        end else if (starve_q < LIMIT) begin
                            starve_d = starve_q + 4'd1;
                        end
                    end
                end
            end
            BUS: begin
                if (!own_cyc) begin
                    state_d = GAP;
                    grant_d = 3'b000;
                    gap_d   = GAP_INIT;
                end
            end
            GAP: begin
                if (gap_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 3'b000;
            end
        endcase
    end

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            state_q  <= IDLE;
            grant_q  <= 3'b000;
            starve_q <= 4'd0;
            gap_q    <= 4'd0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
            gap_q    <= gap_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed plus random bench for sdram_arbiter against an owner/cooldown
// reference model; every cycle checked at the falling edge region.
module tb_sdram_arbiter;

    localparam int LIMIT = 4;
    localparam int GAP   = 2;

    logic        wb_clk = 1'b0;
    logic        wb_rst;
    logic [2:0]  m_cyc, m_stb, m_we;
    logic [65:0] m_adr;
    logic [11:0] m_sel;
    logic [8:0]  m_cti;
    logic [95:0] m_dat_i;
    logic [2:0]  m_ack;
    logic [31:0] m_dat_o;
    logic        s_cyc, s_stb, s_we;
    logic [21:0] s_adr;
    logic [3:0]  s_sel;
    logic [2:0]  s_cti;
    logic [31:0] s_dat_o;
    logic        s_ack;
    logic [31:0] s_dat_i;
    logic [2:0]  grant;

    sdram_arbiter #(.STARVE_LIMIT(LIMIT), .GAP_CYCLES(GAP)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_sel(m_sel), .m_cti(m_cti), .m_dat_i(m_dat_i),
        .m_ack(m_ack), .m_dat_o(m_dat_o),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_sel(s_sel), .s_cti(s_cti), .s_dat_o(s_dat_o),
        .s_ack(s_ack), .s_dat_i(s_dat_i), .grant(grant)
    );

    always #5 wb_clk = ~wb_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference: current owner (-1 none), cycles of cooldown left, CPU losses
    int owner  = -1;
    int cd     = 0;
    int starve = 0;
    logic [2:0] e_ack = 3'b000;
    int rem [3];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic [2:0]  eg, ea;
        logic [31:0] ebus, edat, emd;
        eg = 3'b000; ea = 3'b000; ebus = '0; edat = '0; emd = '0;
        if (!wb_rst && owner >= 0) begin
            eg   = 3'(1 << owner);
            ebus = {m_cyc[owner], m_stb[owner], m_we[owner],
                    m_cti[3*owner +: 3], m_sel[4*owner +: 4],
                    m_adr[22*owner +: 22]};
            edat = m_dat_i[32*owner +: 32];
            if (s_ack && m_cyc[owner]) ea = eg;
            emd  = s_dat_i;
        end
        e_ack = ea;
        chk("grant", 32'(grant), 32'(eg));
        chk("s_bus", {s_cyc, s_stb, s_we, s_cti, s_sel, s_adr}, ebus);
        chk("s_dat_o", s_dat_o, edat);
        chk("m_ack", 32'(m_ack), 32'(ea));
        chk("m_dat_o", m_dat_o, emd);
    endtask

    task automatic model_update();
        logic [2:0] req;
        int w;
        if (wb_rst) begin
            owner = -1; cd = 0; starve = 0;
            return;
        end
        req = m_cyc & m_stb;
        if (owner >= 0) begin
            if (!m_cyc[owner]) begin
                owner = -1;
                cd = GAP;
            end
        end else if (cd > 0) begin
            cd--;
        end else if (req != 3'b000) begin
            if (req[2] && starve >= LIMIT) w = 2;
            else if (req[0]) w = 0;
            else if (req[1]) w = 1;
            else w = 2;
            if (req[2]) starve = (w == 2) ? 0 : ((starve < LIMIT) ? starve + 1 : LIMIT);
            owner = w;
        end
    endtask

    task automatic tick();
        #1 check_all();
        @(posedge wb_clk);
        model_update();
        @(negedge wb_clk);
    endtask

    task automatic set_m(input int i, input logic we, input logic [21:0] adr,
                         input logic [3:0] sel, input logic [2:0] cti,
                         input logic [31:0] dat);
        m_cyc[i] = 1'b1;
        m_stb[i] = 1'b1;
        m_we[i]  = we;
        m_adr[22*i +: 22] = adr;
        m_sel[4*i +: 4]   = sel;
        m_cti[3*i +: 3]   = cti;
        m_dat_i[32*i +: 32] = dat;
    endtask

    task automatic drop(input int i);
        m_cyc[i] = 1'b0;
        m_stb[i] = 1'b0;
    endtask

    task automatic wait_grant(input logic [2:0] exp, input string tag,
                              output int n);
        n = 0;
        while (grant == 3'b000 && n < 50) begin
            tick();
            n++;
        end
        chk(tag, 32'(grant), 32'(exp));
    endtask

    task automatic idle(input int k);
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        for (int j = 0; j < k; j++) tick();
    endtask

    initial begin
        int n;
        wb_rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_sel = '0;
        m_cti = '0; m_dat_i = '0; s_ack = 1'b0; s_dat_i = '0;
        tick();
        m_cyc = 3'b111; m_stb = 3'b111; s_ack = 1'b1; s_dat_i = 32'hFFFF_FFFF;
        #1 chk("rst_grant", 32'(grant), 32'h0);
        chk("rst_scyc", 32'(s_cyc), 32'h0);
        chk("rst_mdat", m_dat_o, 32'h0);
        tick();
        idle(1);
        wb_rst = 1'b0;
        tick();

        // single CPU read
        set_m(2, 1'b0, 22'h000100, 4'hF, 3'b000, 32'h0);
        #1 chk("t1_lat0", 32'(s_cyc), 32'h0);
        tick();
        chk("t1_cyc", 32'(s_cyc), 32'h1);
        chk("t1_adr", 32'(s_adr), 32'h100);
        chk("t1_grant", 32'(grant), 32'h4);
        s_ack = 1'b1; s_dat_i = 32'h1234_5678;
        #1 chk("t1_ack", 32'(m_ack), 32'h4);
        chk("t1_rdat", m_dat_o, 32'h1234_5678);
        tick();
        s_ack = 1'b0;
        tick();
        drop(2);
        tick();
        set_m(2, 1'b0, 22'h000104, 4'hF, 3'b000, 32'h0);
        wait_grant(3'b100, "t1_regrant", n);
        chk("t1_gap", 32'(n), 32'(GAP + 1));
        idle(5);

        // video and CPU together
        set_m(0, 1'b0, 22'h002000, 4'hF, 3'b000, 32'h0);
        set_m(2, 1'b0, 22'h000200, 4'hF, 3'b000, 32'h0);
        tick();
        chk("t2_grant", 32'(grant), 32'h1);
        s_ack = 1'b1;
        #1 chk("t2_noack", 32'(m_ack), 32'h1);
        tick();
        s_ack = 1'b0;
        tick();
        drop(0);
        tick();
        wait_grant(3'b100, "t2_cpu", n);
        chk("t2_wait", 32'(n), 32'(GAP + 1));
        idle(5);

        // video burst, sound write arrives mid-burst
        set_m(0, 1'b0, 22'h003000, 4'hF, 3'b010, 32'h0);
        tick();
        set_m(1, 1'b1, 22'h001000, 4'b0011, 3'b000, 32'hDEAD_BEEF);
        for (int k = 0; k < 4; k++) begin
            s_ack = 1'b1; s_dat_i = $urandom;
            #1 chk("t3_ack", 32'(m_ack), 32'h1);
            chk("t3_cti", 32'(s_cti), 32'h2);
            tick();
            s_ack = 1'b0;
            tick();
        end
        chk("t3_hold", 32'(grant), 32'h1);
        drop(0);
        tick();
        wait_grant(3'b010, "t3_sound", n);
        chk("t5_we", 32'(s_we), 32'h1);
        chk("t5_sel", 32'(s_sel), 32'h3);
        chk("t5_dat", s_dat_o, 32'hDEAD_BEEF);
        s_ack = 1'b1;
        tick();
        s_ack = 1'b0;
        drop(1);
        idle(5);

        // CPU starvation guard
        set_m(0, 1'b0, 22'h004000, 4'hF, 3'b000, 32'h0);
        set_m(2, 1'b0, 22'h000300, 4'hF, 3'b000, 32'h0);
        for (int a = 0; a < 5; a++) begin
            wait_grant((a < 4) ? 3'b001 : 3'b100, "t4_grant", n);
            if (a < 4) begin
                tick();
                drop(0);
                tick();
                set_m(0, 1'b0, 22'(22'h004000 + a), 4'hF, 3'b000, 32'h0);
            end
        end
        tick();
        drop(2);
        tick();
        set_m(2, 1'b0, 22'h000304, 4'hF, 3'b000, 32'h0);
        wait_grant(3'b001, "t4_reset_cnt", n);
        idle(5);

        // async reset mid-burst
        set_m(0, 1'b0, 22'h005000, 4'hF, 3'b010, 32'h0);
        tick();
        s_ack = 1'b1;
        #1 chk("t6_pre", 32'(m_ack), 32'h1);
        #1 wb_rst = 1'b1;
        owner = -1; cd = 0; starve = 0;
        #1 chk("t6_scyc", 32'(s_cyc), 32'h0);
        chk("t6_grant", 32'(grant), 32'h0);
        chk("t6_ack", 32'(m_ack), 32'h0);
        @(negedge wb_clk);
        m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        tick();
        wb_rst = 1'b0;
        set_m(2, 1'b0, 22'h000400, 4'hF, 3'b000, 32'h0);
        #1 chk("t6_lat0", 32'(s_cyc), 32'h0);
        tick();
        chk("t6_cpu", 32'(grant), 32'h4);
        chk("t6_cyc", 32'(s_cyc), 32'h1);
        idle(5);

        // random traffic
        rem[0] = 0; rem[1] = 0; rem[2] = 0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (m_cyc[i]) begin
                    if (e_ack[i]) rem[i]--;
                    if (rem[i] <= 0 || $urandom_range(0, 31) == 0) drop(i);
                    else m_stb[i] = ($urandom_range(0, 3) != 0);
                end else if ($urandom_range(0, 3) == 0) begin
                    rem[i] = $urandom_range(1, 4);
                    set_m(i, 1'($urandom), 22'($urandom), 4'($urandom),
                          (rem[i] > 1) ? 3'b010 : 3'b000, $urandom);
                end
            end
            s_ack = 1'($urandom);
            s_dat_i = $urandom;
            tick();
        end
        idle(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
